uart_echo_buffer: RTL
=====================

Name: uart_echo_buffer

Overview:
Parametrised echo engine between the osdvu `uart` core's receive and transmit handshakes. It supersedes the single-register echo in the iCEstick top level.
- Received bytes are queued in a FIFO, so back-to-back input is no longer lost while TX is busy.
- Optional case folding and CR→CR,LF expansion are applied on the way out.
- Overflow and receive-error status are exported for LEDs or debug.

Parameters:
DATA_WIDTH, 8, width of rx_data/tx_data; case/CRLF logic acts only when DATA_WIDTH=8, otherwise bytes pass through.
DEPTH, 16, FIFO entries; power of two, ≥2.
CASE_MODE, 0, 0 = pass-through, 1 = fold 0x61–0x7A to upper (−0x20), 2 = fold 0x41–0x5A to lower (+0x20).
CRLF_EXPAND, 0, 1 = after sending 0x0D, automatically send 0x0A.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  high = accept RX and start new TX
rx_valid  in  1  one-cycle pulse from core `received`
rx_data  in  DATA_WIDTH  core `rx_byte`
rx_error  in  1  core `recv_error`, qualifies rx_valid
tx_busy  in  1  core `is_transmitting`
tx_start  out  1  to core `transmit`
tx_data  out  DATA_WIDTH  to core `tx_byte`
fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a byte was dropped because the FIFO was full
overflow_clr  in  1  clears overflow; a set event in the same cycle takes priority
err_count  out  8  count of rx_valid&&rx_error, saturates at 255

Behaviour:
Reset (rst_n low, asynchronous):
- tx_start=0, tx_data=0, fifo_level=0, overflow=0, err_count=0.
- FSM goes to IDLE; lf_pending=0.
- Takes effect immediately, including mid-transmission; FIFO contents are discarded.

RX side (per clk):
- Push when rx_valid && !rx_error && enable.
- rx_valid && rx_error: no push; err_count increments unless already at 255.
- rx_valid while enable=0: ignored; no counters change.
- Push while full with no pop in the same cycle: byte dropped, overflow set.
- Push while full with a pop in the same cycle: push accepted, level unchanged.
- Read/write pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are taken from the level counter.

TX FSM, states IDLE, REQ, BUSY:
- IDLE, enable=1, lf_pending=1: tx_data←0x0A, clear lf_pending, tx_start←1, go REQ. lf_pending has priority over the FIFO.
- IDLE, enable=1, FIFO non-empty: pop the head, tx_data←fold(head), tx_start←1, go REQ.
  - If CRLF_EXPAND=1 and the popped byte is 0x0D, set lf_pending.
- REQ: hold tx_start=1 and tx_data stable until tx_busy=1. Then tx_start←0 and go BUSY. There is no timeout.
- BUSY: wait for tx_busy=0, then go IDLE.
- enable falling in REQ or BUSY: the current byte completes normally; no new byte starts while enable=0. FIFO and lf_pending are retained.

Timing and rules:
- Latency: with the FIFO empty and the FSM in IDLE, rx_valid in cycle N gives a write at the cycle-N edge and tx_start=1 from the cycle-N+1 edge. This is one registered stage.
- Per-byte period is set by the core's tx_busy; back-to-back bytes need one IDLE cycle between BUSY exit and the next tx_start.
- Case folding is purely combinational on the popped byte; only values in the listed range are altered.
- fifo_level updates on the same edge as each push and pop.

Test Plan:
1. Reset, enable=1, single rx_valid with 0x41 → tx_start rises 1 cycle later with tx_data=0x41; fifo_level goes 1→0 at pop; tx_start drops the cycle after tx_busy=1.
2. DEPTH=16, tx_busy stuck high, 18 rx_valid pulses → fifo_level=16, overflow=1. Then release tx_busy → exactly 16 bytes echoed, in order. Then pulse overflow_clr → overflow=0.
3. CASE_MODE=1, input "aZ{" (0x61,0x5A,0x7B) → output 0x41,0x5A,0x7B. CASE_MODE=2, input 0x41 → output 0x61.
4. CRLF_EXPAND=1, input 0x0D,0x31 queued together → output sequence 0x0D,0x0A,0x31.
5. 300 rx_valid pulses with rx_error=1 → err_count=255, fifo_level=0, no tx_start.
6. Assert rst_n low while in BUSY with 3 bytes queued → tx_start=0 and fifo_level=0 immediately. After release, no bytes are sent until new input arrives.

Source files
------------

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: FIFO-buffered echo between the uart core's receive and transmit handshakes,
// with optional case folding, CR->CR,LF expansion, sticky overflow and a saturating RX-error count.
module uart_echo_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int CASE_MODE   = 0,
  parameter int CRLF_EXPAND = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    rx_valid,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_error,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow,
  input  logic                    overflow_clr,
  output logic [7:0]              err_count,
  output logic [1:0]              dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  localparam logic [DATA_WIDTH-1:0] CH_CR    = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] CH_LF    = DATA_WIDTH'(8'h0A);
  localparam logic [DATA_WIDTH-1:0] LC_A     = DATA_WIDTH'(8'h61);
  localparam logic [DATA_WIDTH-1:0] LC_Z     = DATA_WIDTH'(8'h7A);
  localparam logic [DATA_WIDTH-1:0] UC_A     = DATA_WIDTH'(8'h41);
  localparam logic [DATA_WIDTH-1:0] UC_Z     = DATA_WIDTH'(8'h5A);
  localparam logic [DATA_WIDTH-1:0] CASE_OFS = DATA_WIDTH'(8'h20);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_level;
  logic                  r_overflow;
  logic [7:0]            r_err_count;
  logic [1:0]            r_state;
  logic                  r_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_lf_pending;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rx_ok;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_is_cr;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_folded;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_rx_ok = rx_valid && !rx_error && enable;
  assign w_pop   = (r_state == ST_IDLE) && enable && !r_lf_pending && !w_empty;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_push  = w_rx_ok && (!w_full || w_pop);
  assign w_drop  = w_rx_ok && w_full && !w_pop;
  assign w_is_cr = (CRLF_EXPAND == 1) && (DATA_WIDTH == 8) && (w_head == CH_CR);

  always_comb begin
    w_folded = w_head;
    if (DATA_WIDTH == 8) begin
      if (CASE_MODE == 1 && w_head >= LC_A && w_head <= LC_Z)
        w_folded = w_head - CASE_OFS;
      else if (CASE_MODE == 2 && w_head >= UC_A && w_head <= UC_Z)
        w_folded = w_head + CASE_OFS;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      if (w_drop)
        r_overflow <= 1'b1;
      else if (overflow_clr)
        r_overflow <= 1'b0;
      if (rx_valid && rx_error && enable && r_err_count != 8'hFF)
        r_err_count <= r_err_count + 8'd1;
    end
  end

  // Handshake: tx_start is a level request with tx_data held stable; the core acknowledges
  // by raising tx_busy, and a new request is only issued after tx_busy has fallen again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
      r_lf_pending <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            if (r_lf_pending) begin
              r_tx_data    <= CH_LF;
              r_lf_pending <= 1'b0;
              r_tx_start   <= 1'b1;
              r_state      <= ST_REQ;
            end else if (!w_empty) begin
              r_tx_data    <= w_folded;
              r_lf_pending <= w_is_cr;
              r_tx_start   <= 1'b1;
              r_state      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (tx_busy) begin
            r_tx_start <= 1'b0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!tx_busy) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign err_count  = r_err_count;
  assign dbg_state  = r_state;
endmodule
